spike_rate_decoder: RTL and testbench
=====================================

Name: spike_rate_decoder

Overview:
- Downstream consumer of the LIF neuron layer: accumulates `spike` outputs from N_CH neurons over a programmable time window.
- At window end it runs a sequential argmax scan (winner-take-all) and presents the winning class index and its spike count on a valid/ready output handshake.
- Converts the spike train back into a classification result for the display/readout logic.

Parameters:
- N_CH, 4, number of neuron spike inputs (channels); must be ≥ 2.
- CNT_W, 8, width of each per-channel spike counter (saturating).
- WIN_W, 8, width of window length and window cycle counter.
- IDX_W, $clog2(N_CH), width of class index.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  time-step enable; spikes sampled and window advanced only when en=1.
- spike_in  in  N_CH  one spike bit per neuron, bit i = channel i.
- window_len  in  WIN_W  time steps per window; sampled on the first enabled cycle of each window; 0 treated as 1.
- out_ready  in  1  downstream accepts result.
- out_valid  out  1  result available.
- class_idx  out  IDX_W  index of channel with highest count.
- class_count  out  CNT_W  spike count of the winning channel.
- no_spike  out  1  all channel counts zero in this window (valid with out_valid).
- missed  out  1  one-cycle pulse when en=1 and any spike_in bit is set while not in COLLECT.
- busy  out  1  high in SCAN and HOLD.

Behaviour:
- Reset (synchronous): state=COLLECT; all counters, window counter, scan index, best registers = 0; out_valid=0, class_idx=0, class_count=0, no_spike=0, missed=0, busy=0. Reset wins over every other event, including a handshake in the same cycle.
- COLLECT:
  - On each cycle with en=1, cnt[i] += spike_in[i], saturating at 2^CNT_W−1.
  - Window counter increments. Window length is latched when the window counter is 0.
  - On the enabled cycle where win_cnt == latched_len−1, that cycle's spikes are still counted, win_cnt→0, state→SCAN.
  - en=0: nothing changes.
- SCAN:
  - Exactly N_CH cycles, independent of en. scan_idx runs 0..N_CH−1.
  - At scan_idx=0, best is loaded with channel 0. For later indices, best is replaced only if cnt[scan_idx] > best_cnt (strictly greater), so ties resolve to the lowest index.
  - After the scan_idx=N_CH−1 cycle: state→HOLD, out_valid=1, class_idx/class_count registered from best, no_spike = (best_cnt==0).
  - Latency: last COLLECT cycle T → out_valid first high in cycle T+N_CH+1.
- HOLD:
  - out_valid, class_idx, class_count and no_spike are held stable until out_ready=1.
  - On a cycle with out_valid & out_ready: all cnt cleared, out_valid→0 next cycle, state→COLLECT. The next window starts on the following enabled cycle.
  - out_ready high before out_valid has no effect.
- Spikes in SCAN/HOLD are not counted. missed is registered, asserting one cycle after the offending input cycle.
- Saturation: a counter at its maximum stays there; compare uses saturated values.
- window_len changes mid-window take effect at the next window only.

Decomposition:
- Shared package snn_pkg holds:
  - state encoding typedef (COLLECT, SCAN, HOLD);
  - default widths CNT_W=8, WIN_W=8;
  - helper constant CNT_MAX.
- One natural sub-module: sat_counter (CNT_W-bit increment-by-1 with saturation, synchronous clear), instantiated N_CH times.
- Argmax comparator and FSM stay in the top level.

Test Plan:
- Basic window: N_CH=4, window_len=4, en=1, spike_in=4'b0010 every cycle → after 4 COLLECT + 4 SCAN cycles, out_valid=1, class_idx=1, class_count=4, no_spike=0.
- Tie and zero:
  - Ch0 and ch2 each spike 3 times in window_len=5 → class_idx=0, class_count=3.
  - No spikes → class_idx=0, class_count=0, no_spike=1.
- Backpressure and missed: hold out_ready=0 for 10 cycles with spike_in=4'b1111 →
  - outputs stay stable;
  - missed pulses each cycle, delayed one cycle;
  - raising out_ready clears out_valid next cycle and the next window counts from 0.
- Saturation: CNT_W=4, window_len=20, ch3 spikes every cycle, ch1 spikes 10 times → class_idx=3, class_count=15.
- en gating and window_len edge cases:
  - window_len=3 with en toggling 1,0,1,0,1 → window closes after 3 enabled cycles.
  - window_len=0 behaves as 1.
- Reset mid-operation: assert reset during SCAN, and separately during HOLD with out_ready=1 → next cycle all outputs 0 and state COLLECT; a fresh window_len=2 with spike_in=4'b0100 gives class_idx=2, class_count=2.

Source files
------------

// File: rtl/snn_pkg.sv
// -----------------------------------------------------------------------------
// snn_pkg
// Shared definitions for the spiking-network readout blocks.
//   state_e    : controller state encoding of the spike-rate decoder
//   DEF_CNT_W  : default per-channel spike counter width
//   DEF_WIN_W  : default window length / window counter width
//   CNT_MAX    : saturation value of a default-width spike counter
// -----------------------------------------------------------------------------
package snn_pkg;

  localparam int DEF_CNT_W = 8;
  localparam int DEF_WIN_W = 8;

  localparam logic [DEF_CNT_W-1:0] CNT_MAX = '1;

  // COLLECT : counting spikes inside the current window
  // SCAN    : sequential argmax over the channel counters
  // HOLD    : result presented, waiting for the consumer
  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SCAN    = 2'd1,
    HOLD    = 2'd2
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Increment-by-one counter that sticks at its all-ones value.
// Ports:
//   clk    in  system clock, rising edge
//   reset  in  synchronous active-high reset, clears the count
//   clr_i  in  synchronous clear (priority over inc_i)
//   inc_i  in  add one this cycle unless already saturated
//   cnt_o  out current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    // NOTE: the default assignment first gives cnt_d a value on every path,
    // so no latch is inferred when neither clear nor increment is active.
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: these counters are explicitly reset because the argmax scan reads
  // every one of them; an unreset count would leak X into the result.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/spike_rate_decoder.sv
// -----------------------------------------------------------------------------
// spike_rate_decoder
// Counts spikes per channel over a programmable window, then runs a
// one-channel-per-cycle argmax and offers the winning class on a
// valid/ready interface.
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   en           in   time-step enable (spikes counted, window advanced)
//   spike_in     in   one spike bit per channel
//   window_len   in   time steps per window, 0 behaves as 1
//   out_ready    in   consumer accepts the result
//   out_valid    out  result available
//   class_idx    out  winning channel index (lowest index on ties)
//   class_count  out  spike count of the winning channel
//   no_spike     out  every channel count was zero
//   missed       out  registered flag: spikes arrived outside COLLECT
//   busy         out  high in SCAN and HOLD
// -----------------------------------------------------------------------------
module spike_rate_decoder
  import snn_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = DEF_CNT_W,
  parameter int WIN_W = DEF_WIN_W,
  parameter int IDX_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [N_CH-1:0]  spike_in,
  input  logic [WIN_W-1:0] window_len,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] class_idx,
  output logic [CNT_W-1:0] class_count,
  output logic             no_spike,
  output logic             missed,
  output logic             busy
);

  state_e           state_q,       state_d;
  logic [WIN_W-1:0] win_cnt_q,     win_cnt_d;
  logic [WIN_W-1:0] len_q,         len_d;
  logic [IDX_W-1:0] scan_idx_q,    scan_idx_d;
  logic [IDX_W-1:0] best_idx_q,    best_idx_d;
  logic [CNT_W-1:0] best_cnt_q,    best_cnt_d;
  logic [IDX_W-1:0] class_idx_q,   class_idx_d;
  logic [CNT_W-1:0] class_count_q, class_count_d;
  logic             out_valid_q,   out_valid_d;
  logic             no_spike_q,    no_spike_d;
  logic             missed_q,      missed_d;

  logic [CNT_W-1:0] cnt [N_CH];
  logic [N_CH-1:0]  cnt_inc;
  logic             collect_step;
  logic             handshake;
  logic [WIN_W-1:0] len_in;
  logic [WIN_W-1:0] cur_len;
  logic [CNT_W-1:0] cand_cnt;
  logic             take;

  assign collect_step = en && (state_q == COLLECT);
  assign handshake    = (state_q == HOLD) && out_valid_q && out_ready;
  assign cnt_inc      = collect_step ? spike_in : '0;

  for (genvar g = 0; g < N_CH; g++) begin : g_cnt
    sat_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr_i (handshake),
      .inc_i (cnt_inc[g]),
      .cnt_o (cnt[g])
    );
  end

  // The first step of a window uses the live length input (so a length of 1
  // closes immediately); later steps use the value latched on that first step.
  assign len_in  = (window_len == '0) ? WIN_W'(1) : window_len;
  assign cur_len = (win_cnt_q == '0) ? len_in : len_q;

  // Index 0 unconditionally seeds the running best; strict '>' keeps the
  // lowest index on ties.
  assign cand_cnt = cnt[scan_idx_q];
  assign take     = (scan_idx_q == '0) || (cand_cnt > best_cnt_q);

  always_comb begin
    state_d       = state_q;
    win_cnt_d     = win_cnt_q;
    len_d         = len_q;
    scan_idx_d    = scan_idx_q;
    best_idx_d    = best_idx_q;
    best_cnt_d    = best_cnt_q;
    class_idx_d   = class_idx_q;
    class_count_d = class_count_q;
    out_valid_d   = out_valid_q;
    no_spike_d    = no_spike_q;
    missed_d      = en && (|spike_in) && (state_q != COLLECT);

    unique case (state_q)
      COLLECT: begin
        if (en) begin
          if (win_cnt_q == '0) begin
            len_d = len_in;
          end
          if (win_cnt_q == (cur_len - WIN_W'(1))) begin
            win_cnt_d  = '0;
            scan_idx_d = '0;
            state_d    = SCAN;
          end else begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
          end
        end
      end

      SCAN: begin
        best_cnt_d = take ? cand_cnt   : best_cnt_q;
        best_idx_d = take ? scan_idx_q : best_idx_q;
        if (scan_idx_q == IDX_W'(N_CH - 1)) begin
          // Publish this cycle's comparison result directly.
          state_d       = HOLD;
          scan_idx_d    = '0;
          out_valid_d   = 1'b1;
          class_idx_d   = best_idx_d;
          class_count_d = best_cnt_d;
          no_spike_d    = (best_cnt_d == '0);
        end else begin
          scan_idx_d = scan_idx_q + IDX_W'(1);
        end
      end

      HOLD: begin
        if (handshake) begin
          out_valid_d = 1'b0;
          state_d     = COLLECT;
        end
      end

      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= COLLECT;
      win_cnt_q     <= '0;
      len_q         <= '0;
      scan_idx_q    <= '0;
      best_idx_q    <= '0;
      best_cnt_q    <= '0;
      class_idx_q   <= '0;
      class_count_q <= '0;
      out_valid_q   <= 1'b0;
      no_spike_q    <= 1'b0;
      missed_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      win_cnt_q     <= win_cnt_d;
      len_q         <= len_d;
      scan_idx_q    <= scan_idx_d;
      best_idx_q    <= best_idx_d;
      best_cnt_q    <= best_cnt_d;
      class_idx_q   <= class_idx_d;
      class_count_q <= class_count_d;
      out_valid_q   <= out_valid_d;
      no_spike_q    <= no_spike_d;
      missed_q      <= missed_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign class_idx   = class_idx_q;
  assign class_count = class_count_q;
  assign no_spike    = no_spike_q;
  assign missed      = missed_q;
  assign busy        = (state_q != COLLECT);

endmodule

// File: tb/tb_spike_rate_decoder.sv
// -----------------------------------------------------------------------------
// tb_spike_rate_decoder
// Directed stimulus with hand-computed expectations. Two decoders share the
// inputs: the default 8-bit counter build and a 4-bit counter build that
// exercises saturation. Inputs change and outputs are sampled on the falling
// clock edge, half a period away from the active edge.
// -----------------------------------------------------------------------------
module tb_spike_rate_decoder;

  localparam int N_CH = 4;

  logic       clk;
  logic       reset;
  logic       en;
  logic [3:0] spike_in;
  logic [7:0] window_len;
  logic       out_ready;

  logic       out_valid,   no_spike,   missed,   busy;
  logic [1:0] class_idx;
  logic [7:0] class_count;

  logic       out_valid4,  no_spike4,  missed4,  busy4;
  logic [1:0] class_idx4;
  logic [3:0] class_count4;

  int checks = 0;
  int errors = 0;

  spike_rate_decoder #(
    .N_CH  (N_CH),
    .CNT_W (8),
    .WIN_W (8)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .spike_in    (spike_in),
    .window_len  (window_len),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .class_idx   (class_idx),
    .class_count (class_count),
    .no_spike    (no_spike),
    .missed      (missed),
    .busy        (busy)
  );

  spike_rate_decoder #(
    .N_CH  (N_CH),
    .CNT_W (4),
    .WIN_W (8)
  ) u_dut4 (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .spike_in    (spike_in),
    .window_len  (window_len),
    .out_ready   (out_ready),
    .out_valid   (out_valid4),
    .class_idx   (class_idx4),
    .class_count (class_count4),
    .no_spike    (no_spike4),
    .missed      (missed4),
    .busy        (busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic collect(input logic [3:0] pat);
    en       = 1'b1;
    spike_in = pat;
    tick();
  endtask

  task automatic idle();
    en       = 1'b0;
    spike_in = 4'b0000;
  endtask

  task automatic wait_valid(input string tag);
    idle();
    for (int i = 0; (i < N_CH + 4) && !out_valid; i++) tick();
    check({tag, "_valid"}, 32'(out_valid), 1);
  endtask

  task automatic expect_result(input string tag, input int idx, input int cnt8,
                               input int cnt4, input int nos);
    wait_valid(tag);
    check({tag, "_idx"},     32'(class_idx),    idx);
    check({tag, "_cnt"},     32'(class_count),  cnt8);
    check({tag, "_nospike"}, 32'(no_spike),     nos);
    check({tag, "_busy"},    32'(busy),         1);
    check({tag, "_valid4"},  32'(out_valid4),   1);
    check({tag, "_idx4"},    32'(class_idx4),   idx);
    check({tag, "_cnt4"},    32'(class_count4), cnt4);
    check({tag, "_nospike4"}, 32'(no_spike4),   nos);
  endtask

  task automatic accept(input string tag);
    out_ready = 1'b1;
    tick();
    check({tag, "_acc_valid"}, 32'(out_valid), 0);
    check({tag, "_acc_busy"},  32'(busy),      0);
    out_ready = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"},   32'(out_valid),   0);
    check({tag, "_idx"},     32'(class_idx),   0);
    check({tag, "_cnt"},     32'(class_count), 0);
    check({tag, "_nospike"}, 32'(no_spike),    0);
    check({tag, "_missed"},  32'(missed),      0);
    check({tag, "_busy"},    32'(busy),        0);
    check({tag, "_busy4"},   32'(busy4),       0);
    check({tag, "_missed4"}, 32'(missed4),     0);
  endtask

  initial begin
    reset      = 1'b1;
    en         = 1'b0;
    spike_in   = 4'b0000;
    window_len = 8'd0;
    out_ready  = 1'b0;
    tick();
    tick();
    check_zero("reset");
    reset = 1'b0;

    // Basic window: channel 1 every step of a 4-step window, exact latency.
    window_len = 8'd4;
    repeat (4) collect(4'b0010);
    idle();
    check("basic_scan_busy", 32'(busy), 1);
    check("basic_scan_novalid", 32'(out_valid), 0);
    repeat (3) tick();
    check("basic_latency_early", 32'(out_valid), 0);
    tick();
    check("basic_latency", 32'(out_valid), 1);
    expect_result("basic", 1, 4, 4, 0);
    accept("basic");

    // Tie between channels 0 and 2 resolves to the lower index.
    window_len = 8'd5;
    repeat (3) collect(4'b0101);
    repeat (2) collect(4'b0000);
    expect_result("tie", 0, 3, 3, 0);
    accept("tie");

    // A later channel strictly ahead replaces an earlier nonzero best.
    window_len = 8'd3;
    collect(4'b1010);
    collect(4'b1010);
    collect(4'b1000);
    expect_result("greater", 3, 3, 3, 0);
    accept("greater");

    // Empty window.
    window_len = 8'd2;
    repeat (2) collect(4'b0000);
    expect_result("zero", 0, 0, 0, 1);
    accept("zero");

    // Backpressure with spikes arriving during HOLD.
    window_len = 8'd2;
    repeat (2) collect(4'b0001);
    wait_valid("bp");
    en        = 1'b1;
    spike_in  = 4'b1111;
    out_ready = 1'b0;
    check("bp_missed_delay", 32'(missed), 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold_valid",  32'(out_valid),   1);
      check("bp_hold_idx",    32'(class_idx),   0);
      check("bp_hold_cnt",    32'(class_count), 2);
      check("bp_hold_missed", 32'(missed),      1);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_valid",  32'(out_valid), 0);
    check("bp_release_missed", 32'(missed),    1);
    out_ready  = 1'b0;
    window_len = 8'd3;
    collect(4'b0000);
    check("bp_collect_missed", 32'(missed), 0);
    collect(4'b0010);
    check("bp_collect_missed2", 32'(missed), 0);
    collect(4'b0000);
    expect_result("bp_next", 1, 1, 1, 0);
    accept("bp_next");

    // Saturation: 20 steps, ch3 every step, ch1 on the first 10.
    window_len = 8'd20;
    for (int i = 0; i < 20; i++) collect((i < 10) ? 4'b1010 : 4'b1000);
    expect_result("sat", 3, 20, 15, 0);
    accept("sat");

    // Enable gating, plus a mid-window length change that must wait.
    window_len = 8'd3;
    collect(4'b0100);
    window_len = 8'd1;
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    en = 1'b0;
    tick();
    check("gate_still_open", 32'(busy), 0);
    en = 1'b1;
    tick();
    check("gate_closed", 32'(busy), 1);
    expect_result("gate", 2, 3, 3, 0);
    accept("gate");

    // Length 0 behaves as a single-step window.
    window_len = 8'd0;
    collect(4'b1000);
    check("len0_closed", 32'(busy), 1);
    expect_result("len0", 3, 1, 1, 0);
    accept("len0");

    // Reset during SCAN.
    window_len = 8'd2;
    repeat (2) collect(4'b0001);
    en       = 1'b1;
    spike_in = 4'b1111;
    tick();
    check("rst_scan_pre_busy",   32'(busy),   1);
    check("rst_scan_pre_missed", 32'(missed), 1);
    reset = 1'b1;
    tick();
    check_zero("rst_scan");
    reset = 1'b0;
    idle();
    window_len = 8'd2;
    repeat (2) collect(4'b0100);
    expect_result("rst_scan_fresh", 2, 2, 2, 0);

    // Reset during HOLD while the consumer is also accepting.
    reset     = 1'b1;
    out_ready = 1'b1;
    tick();
    check_zero("rst_hold");
    reset     = 1'b0;
    out_ready = 1'b0;
    window_len = 8'd2;
    repeat (2) collect(4'b0100);
    expect_result("rst_hold_fresh", 2, 2, 2, 0);
    accept("rst_hold_fresh");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
